// File: rtl/slowena_gen.sv
// slowena_gen: programmable enable-pulse generator feeding the decade counter.
// Free-runs at a loadable divide ratio, or issues one pulse per step request while halted.
//
// Ports:
//   clk        system clock, rising edge active
//   reset      asynchronous active-low reset
//   run        level, 1 = free-run, 0 = halt
//   step       level, each rising edge while halted requests one pulse
//   div_load   one-cycle strobe, loads div_value (0 clamps to 1)
//   div_value  new divide ratio
//   slowena    registered one-cycle enable pulse
//   running    registered, 1 while in RUN
//   phase      registered current phase count
module slowena_gen #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    output logic                 slowena,
    output logic                 running,
    output logic [DIV_WIDTH-1:0] phase
);

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] div_reg;
    logic                 step_q;
    logic                 step_rise;
    logic [DIV_WIDTH-1:0] div_clamped;
    logic                 phase_last;

    assign step_rise   = step & ~step_q;
    assign div_clamped = (div_value == '0) ? DIV_WIDTH'(1) : div_value;
    assign phase_last  = (phase == div_reg - DIV_WIDTH'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= HALT;
            div_reg <= DIV_WIDTH'(DEFAULT_DIV);
            phase   <= '0;
            slowena <= 1'b0;
            running <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            // step_q follows step in every state so a step held through
            // RUN->HALT is not seen as a fresh request.
            step_q <= step;
            if (div_load) begin
                // A load restarts counting; state still follows run.
                div_reg <= div_clamped;
                phase   <= '0;
                slowena <= 1'b0;
                state   <= run ? RUN : HALT;
                running <= run;
            end else begin
                unique case (state)
                    HALT: begin
                        phase <= '0;
                        if (run) begin
                            // Entering RUN swallows a coincident step edge.
                            state   <= RUN;
                            running <= 1'b1;
                            slowena <= 1'b0;
                        end else begin
                            running <= 1'b0;
                            slowena <= step_rise;
                        end
                    end
                    RUN: begin
                        if (!run) begin
                            // Leaving RUN drops any pulse due on this edge.
                            state   <= HALT;
                            running <= 1'b0;
                            phase   <= '0;
                            slowena <= 1'b0;
                        end else if (phase_last) begin
                            running <= 1'b1;
                            phase   <= '0;
                            slowena <= 1'b1;
                        end else begin
                            running <= 1'b1;
                            phase   <= phase + DIV_WIDTH'(1);
                            slowena <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= HALT;
                        running <= 1'b0;
                        phase   <= '0;
                        slowena <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slowena_gen.sv
// Testbench for slowena_gen: randomized and directed stimulus, a
// count-since-restart reference model, and a queue-based scoreboard.
module tb_slowena_gen;

    localparam int W  = 16;
    localparam int DD = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         run = 1'b0;
    logic         step = 1'b0;
    logic         div_load = 1'b0;
    logic [W-1:0] div_value = '0;
    logic         slowena;
    logic         running;
    logic [W-1:0] phase;

    slowena_gen #(.DIV_WIDTH(W), .DEFAULT_DIV(DD)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .div_load  (div_load),
        .div_value (div_value),
        .slowena   (slowena),
        .running   (running),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // Stand-in decade counter driven by slowena.
    logic [3:0] dec = 4'd0;
    int         wraps = 0;
    logic       dec_clr = 1'b0;
    always @(posedge clk) begin
        if (dec_clr) begin
            dec   <= 4'd0;
            wraps <= 0;
        end else if (slowena) begin
            dec   <= (dec == 4'd9) ? 4'd0 : dec + 4'd1;
            wraps <= wraps + ((dec == 4'd9) ? 1 : 0);
        end
    end

    typedef struct {
        logic         s;
        logic         r;
        logic [W-1:0] p;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: in RUN, outputs derive from the number of edges
    // since the last restart (cnt): pulse when cnt is a nonzero multiple
    // of the divide ratio, phase = cnt mod ratio.
    bit   m_run;
    int   m_div;
    int   m_cnt;
    logic m_prev;

    function automatic void model_reset();
        m_run  = 1'b0;
        m_div  = DD;
        m_cnt  = 0;
        m_prev = 1'b0;
    endfunction

    function automatic exp_t model_edge(input logic r, input logic s,
                                        input logic l, input int v);
        exp_t e;
        if (l) begin
            m_div = (v == 0) ? 1 : v;
            m_cnt = 0;
            m_run = r;
            e = '{1'b0, r, '0};
        end else if (!m_run) begin
            if (r) begin
                m_run = 1'b1;
                m_cnt = 0;
                e = '{1'b0, 1'b1, '0};
            end else begin
                e = '{s & ~m_prev, 1'b0, '0};
            end
        end else if (!r) begin
            m_run = 1'b0;
            e = '{1'b0, 1'b0, '0};
        end else begin
            m_cnt++;
            e = '{((m_cnt % m_div) == 0), 1'b1, W'(m_cnt % m_div)};
        end
        m_prev = s;
        return e;
    endfunction

    task automatic chk(input string n, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s actual=%0d required=%0d t=%0t", n, act, req, $time);
    endtask

    // One clock edge of stimulus; the expected result goes to the queue.
    task automatic edge_drive(input logic r, input logic s,
                              input logic l, input int v);
        @(negedge clk);
        #1;
        run       = r;
        step      = s;
        div_load  = l;
        div_value = W'(v);
        q.push_back(model_edge(r, s, l, v));
    endtask

    // Reset asserted mid-cycle and released just before the next edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset     = 1'b0;
        run       = 1'b0;
        step      = 1'b0;
        div_load  = 1'b0;
        div_value = '0;
        #1;
        chk("rst_slowena", int'(slowena), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_phase", int'(phase), 0);
        #2;
        reset = 1'b1;
        model_reset();
        q.push_back(model_edge(1'b0, 1'b0, 1'b0, 0));
    endtask

    // Monitor: compares every registered output one step after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("slowena", int'(slowena), int'(e.s));
                chk("running", int'(running), int'(e.r));
                chk("phase", int'(phase), int'(e.p));
            end
        end
    end

    initial begin
        bit r_rand;
        model_reset();

        // Free-run at default ratio.
        do_reset();
        edge_drive(1, 0, 0, 0);
        repeat (32) edge_drive(1, 0, 0, 0);
        edge_drive(0, 0, 0, 0);

        // Step pulses in HALT, then step held high.
        repeat (3) begin
            edge_drive(0, 1, 0, 0);
            edge_drive(0, 0, 0, 0);
            edge_drive(0, 0, 0, 0);
        end
        repeat (20) edge_drive(0, 1, 0, 0);
        edge_drive(0, 0, 0, 0);

        // Load 3 mid-period, then load 0 (clamped to 1).
        edge_drive(1, 0, 0, 0);
        repeat (7) edge_drive(1, 0, 0, 0);
        edge_drive(1, 0, 1, 3);
        repeat (10) edge_drive(1, 0, 0, 0);
        edge_drive(1, 0, 1, 0);
        repeat (6) edge_drive(1, 0, 0, 0);

        // Drop run at phase 9; then run and step rise together.
        do_reset();
        edge_drive(1, 0, 0, 0);
        repeat (9) edge_drive(1, 0, 0, 0);
        edge_drive(0, 0, 0, 0);
        edge_drive(0, 0, 0, 0);
        edge_drive(1, 1, 0, 0);
        repeat (4) edge_drive(1, 1, 0, 0);
        edge_drive(0, 1, 0, 0);
        edge_drive(0, 1, 0, 0);

        // Reset while slowena is high; default ratio must come back.
        do_reset();
        edge_drive(1, 0, 1, 5);
        repeat (5) edge_drive(1, 0, 0, 0);
        chk("pre_rst_pulse_seen", int'(q.size()), 1);
        @(posedge clk);
        #2;
        chk("pulse_before_reset", int'(slowena), 1);
        do_reset();
        edge_drive(1, 0, 0, 0);
        repeat (21) edge_drive(1, 0, 0, 0);

        // Decade counter driven at ratio 4 for 60 cycles.
        do_reset();
        dec_clr = 1'b1;
        edge_drive(1, 0, 1, 4);
        @(posedge clk);
        #1;
        dec_clr = 1'b0;
        repeat (61) edge_drive(1, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("decade_value", int'(dec), 5);
        chk("decade_wraps", wraps, 1);

        // Randomized traffic.
        do_reset();
        r_rand = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            int v;
            if ($urandom_range(0, 29) == 0) r_rand = ~r_rand;
            v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 300))
                                            : int'($urandom_range(0, 7));
            edge_drive(r_rand, ($urandom_range(0, 2) == 0),
                       ($urandom_range(0, 39) == 0), v);
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        edge_drive(0, 0, 0, 0);

        repeat (4) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
